// File: rtl/rcp_iter.sv
// Iterative Newton-Raphson reciprocal: power-of-two seed from the operand bit length,
// then ITERS passes through one shared rcp_stage; result ~ 2^WIDTH / a over valid/ready.

module rcp_stage #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] est_i,
   output logic [WIDTH-1:0] est_o
);
   localparam int PW = 2 * WIDTH;

   // est' = est * (2^(W+1) - a*est) >> W, all products truncated to 2W bits
   function automatic logic [WIDTH-1:0] nr_step(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] est);
      logic [PW-1:0] ae;
      logic [PW-1:0] diff;
      logic [PW-1:0] prod;
      ae   = PW'(a) * PW'(est);
      diff = (PW'(2) << WIDTH) - ae;
      prod = PW'(est) * diff;
      return prod[PW-1:WIDTH];
   endfunction

   assign est_o = nr_step(a_i, est_i);
endmodule

module rcp_iter #(
   parameter int WIDTH = 16,
   parameter int ITERS = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] rcp_o,
   output logic             dz_o
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [3:0] LAST = 4'(ITERS);

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] est_q;
   logic [WIDTH-1:0] est_d;
   logic [3:0]       cnt_q;
   logic             dz_q;
   logic             rdy_q;
   logic             vld_q;

   // Seed is 1 << (WIDTH - bitlen(a)); the highest set bit of a wins.
   function automatic logic [WIDTH-1:0] seed(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] s;
      s = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (v[i]) begin
            s = '0;
            s[WIDTH-1-i] = 1'b1;
         end
      end
      return s;
   endfunction

   rcp_stage #(.WIDTH(WIDTH)) u_stage (
      .a_i   (a_q),
      .est_i (est_q),
      .est_o (est_d)
   );

   // BUSY spends ITERS cycles updating est_q and one more entering DONE.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         a_q     <= '0;
         est_q   <= '0;
         cnt_q   <= '0;
         dz_q    <= 1'b0;
         rdy_q   <= 1'b1;
         vld_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid_i) begin
                  a_q   <= a_i;
                  cnt_q <= '0;
                  rdy_q <= 1'b0;
                  if (a_i == '0) begin
                     est_q   <= '1;
                     dz_q    <= 1'b1;
                     vld_q   <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     est_q   <= seed(a_i);
                     dz_q    <= 1'b0;
                     state_q <= BUSY;
                  end
               end
            end
            BUSY: begin
               cnt_q <= cnt_q + 4'd1;
               if (cnt_q == LAST) begin
                  vld_q   <= 1'b1;
                  state_q <= DONE;
               end else begin
                  est_q <= est_d;
               end
            end
            DONE: begin
               if (out_ready_i) begin
                  vld_q   <= 1'b0;
                  rdy_q   <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready_o  = rdy_q;
   assign out_valid_o = vld_q;
   assign rcp_o       = est_q;
   assign dz_o        = dz_q;
endmodule

// File: tb/tb_rcp_iter.sv
// Bench for rcp_iter: directed vectors, handshake corners, async reset mid-operation,
// and random operands against an arithmetic Newton-Raphson reference.

module tb_rcp_iter;
   localparam int WIDTH = 16;
   localparam int ITERS = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [15:0] a = '0;
   logic        in_ready;
   logic        out_valid;
   logic [15:0] rcp;
   logic        dz;

   int tests = 0;
   int fails = 0;
   time accept_t = 0;

   always #5 clk = ~clk;

   rcp_iter #(.WIDTH(WIDTH), .ITERS(ITERS)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .a_i         (a),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .rcp_o       (rcp),
      .dz_o        (dz)
   );

   function automatic logic [15:0] model(input int unsigned av);
      longint unsigned est, p, x;
      if (av == 0) return 16'hFFFF;
      p = 0;
      x = av;
      while (x != 0) begin
         p++;
         x >>= 1;
      end
      est = 64'd1 << (16 - p);
      repeat (ITERS) est = ((est * ((64'd2 << 16) - av * est)) & 64'hFFFF_FFFF) >> 16;
      return est[15:0];
   endfunction

   // Called at a negedge with the unit idle; returns at a negedge after the transfer.
   task automatic do_op(input logic [15:0] av, input int stall,
                        output logic [15:0] r, output logic d, output int lat);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL op_in_ready got=%b want=1", in_ready);
      end
      a = av;
      in_valid = 1'b1;
      @(posedge clk);
      accept_t = $time;
      #1 in_valid = 1'b0;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!out_valid && lat < 50);
      r = rcp;
      d = dz;
      repeat (stall) begin
         @(negedge clk);
         tests++;
         if (rcp !== r || dz !== d || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL stall_hold rcp=%0d dz=%b vld=%b want rcp=%0d dz=%b vld=1",
                     rcp, dz, out_valid, r, d);
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL release vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      #12;
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || rcp !== 16'd0 || dz !== 1'b0) begin
         fails++;
         $display("FAIL reset rdy=%b vld=%b rcp=%0d dz=%b want 1 0 0 0",
                  in_ready, out_valid, rcp, dz);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_vectors();
      logic [15:0] av [5] = '{16'd3, 16'd256, 16'd1, 16'h8000, 16'hFFFF};
      logic [15:0] ex [5];
      logic [15:0] r;
      logic d;
      int lat;
      ex[0] = 16'd21845;
      ex[1] = 16'd255;
      ex[2] = 16'd65535;
      ex[3] = model(32'h8000);
      ex[4] = model(32'hFFFF);
      for (int i = 0; i < 5; i++) begin
         do_op(av[i], 0, r, d, lat);
         tests++;
         if (r !== ex[i] || d !== 1'b0 || lat != ITERS + 1) begin
            fails++;
            $display("FAIL vector a=%0d got rcp=%0d dz=%b lat=%0d want rcp=%0d dz=0 lat=%0d",
                     av[i], r, d, lat, ex[i], ITERS + 1);
         end
      end
   endtask

   task automatic test_zero();
      logic [15:0] r;
      logic d;
      int lat;
      do_op(16'd0, 2, r, d, lat);
      tests++;
      if (r !== 16'hFFFF || d !== 1'b1 || lat != 1) begin
         fails++;
         $display("FAIL zero got rcp=%h dz=%b lat=%0d want ffff 1 1", r, d, lat);
      end
      do_op(16'd3, 0, r, d, lat);
      tests++;
      if (r !== 16'd21845 || d !== 1'b0) begin
         fails++;
         $display("FAIL after_zero got rcp=%0d dz=%b want 21845 0", r, d);
      end
   endtask

   task automatic test_backpressure();
      int n;
      a = 16'd3;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 50);
      in_valid = 1'b1;
      a = 16'd5;
      repeat (10) begin
         @(negedge clk);
         tests++;
         if (rcp !== 16'd21845 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL backpressure rcp=%0d rdy=%b vld=%b want 21845 0 1",
                     rcp, in_ready, out_valid);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      repeat (2) begin
         @(negedge clk);
         tests++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release vld=%b rdy=%b want 0 1", out_valid, in_ready);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] r;
      logic d;
      int lat;
      a = 16'd3;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || rcp !== 16'd0 || dz !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid rdy=%b vld=%b rcp=%0d dz=%b want 1 0 0 0",
                  in_ready, out_valid, rcp, dz);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         tests++;
         if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_noresult vld=%b want 0", out_valid);
         end
      end
      do_op(16'd256, 0, r, d, lat);
      tests++;
      if (r !== 16'd255 || d !== 1'b0 || lat != ITERS + 1) begin
         fails++;
         $display("FAIL reset_mid_next got rcp=%0d dz=%b lat=%0d want 255 0 %0d",
                  r, d, lat, ITERS + 1);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] r;
      logic d;
      int lat;
      time prev;
      do_op(16'd7, 0, r, d, lat);
      prev = accept_t;
      for (int i = 0; i < 3; i++) begin
         do_op(16'(100 + i), 0, r, d, lat);
         tests++;
         if (accept_t - prev != (ITERS + 3) * 10) begin
            fails++;
            $display("FAIL back_to_back period=%0t want %0d", accept_t - prev, (ITERS + 3) * 10);
         end
         prev = accept_t;
      end
   endtask

   task automatic test_random();
      logic [15:0] r, ex, av;
      logic d;
      int lat;
      int unsigned fl;
      for (int i = 0; i < 2000; i++) begin
         av = 16'($urandom_range(1, 65535));
         do_op(av, int'($urandom_range(0, 3)), r, d, lat);
         ex = model(32'(av));
         fl = 32'd65536 / 32'(av);
         tests++;
         if (r !== ex || d !== 1'b0 || lat != ITERS + 1) begin
            fails++;
            $display("FAIL random a=%0d got rcp=%0d dz=%b lat=%0d want rcp=%0d dz=0 lat=%0d",
                     av, r, d, lat, ex, ITERS + 1);
         end
         tests++;
         if (32'(r) > fl || 32'(r) + 1 < fl) begin
            fails++;
            $display("FAIL random_bound a=%0d got rcp=%0d want in [%0d,%0d]", av, r, fl - 1, fl);
         end
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_zero();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
